// File: rtl/sync_bus_filter.sv
// Multi-channel synchroniser with a per-channel stability filter, edge pulses and sticky event flags.
// Define SYNC_BUS_GLITCH_FILTER_EN to build the filter counters; otherwise dout follows the synchronised input.
module sync_bus_filter #(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] ev_sticky,
  input  logic [WIDTH-1:0] ev_clr,
  output logic             any_change
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bus_filter: STAGES must be at least 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("sync_bus_filter: FILT_CYCLES must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_bus_filter: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             any_q, any_d;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[STAGES-1];

`ifdef SYNC_BUS_GLITCH_FILTER_EN
  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_filt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd_b;

    // Counter only runs while s disagrees with dout; any agreement discards the partial run.
    always_comb begin
      cnt_d = '0;
      upd_b = 1'b0;
      if (s[gi] != dout_q[gi]) begin
        if (cnt_q == CNT_MAX) begin
          upd_b = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign upd[gi] = upd_b;
  end
`else
  assign upd = s ^ dout_q;
`endif

  always_comb begin
    dout_d   = (dout_q & ~upd) | (s & upd);
    rise_d   = upd & s;
    fall_d   = upd & ~s;
    sticky_d = (sticky_q & ~ev_clr) | rise_d | fall_d;
    any_d    = |upd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      any_q    <= any_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign ev_sticky  = sticky_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_sync_bus_filter.sv
// Scoreboard bench for sync_bus_filter: a window-based reference model queues expected outputs per edge.
// A monitor pops one expectation per clock and compares it with the DUT outputs.
module tb_sync_bus_filter;
  localparam int W  = 4;
  localparam int ST = 2;
  localparam int FC = 3;
  localparam logic [W-1:0] RV = 4'b0000;
`ifdef SYNC_BUS_GLITCH_FILTER_EN
  localparam int EFF = FC;
`else
  localparam int EFF = 1;
`endif

  typedef struct packed {
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] sticky;
    logic         any;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din, ev_clr;
  logic [W-1:0] dout, rise, fall, ev_sticky;
  logic         any_change;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  // Reference state: din history models the synchroniser delay, s history the stability window.
  logic [W-1:0] din_hist[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_dout, m_sticky;

  sync_bus_filter #(
    .WIDTH(W), .STAGES(ST), .FILT_CYCLES(FC), .RST_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .ev_sticky(ev_sticky), .ev_clr(ev_clr), .any_change(any_change)
  );

  always #5 clk = ~clk;

  // dout[i] takes the synchronised value once the last EFF samples all disagree with it.
  task automatic model_edge(input logic [W-1:0] d, input logic [W-1:0] c, input logic r);
    exp_t         e;
    logic [W-1:0] s, upd;
    if (r) begin
      din_hist.delete();
      s_hist.delete();
      repeat (ST) din_hist.push_back(RV);
      repeat (EFF) s_hist.push_back(RV);
      m_dout   = RV;
      m_sticky = '0;
      e.dout = RV; e.rise = '0; e.fall = '0; e.sticky = '0; e.any = 1'b0;
    end else begin
      s = din_hist.pop_front();
      din_hist.push_back(d);
      s_hist.push_back(s);
      if (s_hist.size() > EFF) void'(s_hist.pop_front());
      for (int i = 0; i < W; i++) begin
        upd[i] = 1'b1;
        foreach (s_hist[j]) if (s_hist[j][i] == m_dout[i]) upd[i] = 1'b0;
      end
      e.rise   = upd & s;
      e.fall   = upd & ~s;
      m_dout   = (m_dout & ~upd) | (s & upd);
      m_sticky = (m_sticky & ~c) | upd;
      e.dout   = m_dout;
      e.sticky = m_sticky;
      e.any    = |upd;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] d, input logic [W-1:0] c, input logic r);
    din    = d;
    ev_clr = c;
    rst    = r;
    model_edge(d, c, r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if (dout !== mon_e.dout || rise !== mon_e.rise || fall !== mon_e.fall ||
          ev_sticky !== mon_e.sticky || any_change !== mon_e.any) begin
        n_fail++;
        $display("[TB] FAIL outputs t=%0t: got dout=%b rise=%b fall=%b sticky=%b any=%b, want dout=%b rise=%b fall=%b sticky=%b any=%b",
                 $time, dout, rise, fall, ev_sticky, any_change,
                 mon_e.dout, mon_e.rise, mon_e.fall, mon_e.sticky, mon_e.any);
      end else begin
        $display("[TB] t=%0t dout=%b rise=%b fall=%b sticky=%b any=%b ok",
                 $time, dout, rise, fall, ev_sticky, any_change);
      end
    end
  end

  initial begin
    logic [W-1:0] d, c;
    logic         r;
    din = '0; ev_clr = '0; rst = 1'b1;

    repeat (5) step(4'hF, 4'h0, 1'b1);           // reset held with inputs high
    repeat (4) step(4'h0, 4'h0, 1'b0);
    repeat (8) step(4'h1, 4'h0, 1'b0);           // channel 0 rises and is held
    repeat (2) step(4'h3, 4'h0, 1'b0);           // channel 1 two-cycle glitch
    repeat (6) step(4'h1, 4'h0, 1'b0);
    repeat (8) step(4'h0, 4'h1, 1'b0);           // clear held across the channel 0 fall
    repeat (2) step(4'h0, 4'h0, 1'b0);
    repeat (8) step(4'hA, 4'h0, 1'b0);           // simultaneous rises
    repeat (2) step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b1);                      // reset mid-qualification
    repeat (6) step(4'h0, 4'h0, 1'b0);
    step(4'h4, 4'h0, 1'b0);                      // single-cycle glitch on channel 2
    repeat (6) step(4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b1);
    repeat (8) step(4'hF, 4'h0, 1'b0);           // post-reset transition away from RST_VAL

    d = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(3) == 0) d[i] = ~d[i];
      for (int i = 0; i < W; i++) c[i] = ($urandom_range(7) == 0);
      r = ($urandom_range(199) == 0);
      step(d, c, r);
    end

    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
